// File: rtl/transfer_sequencer.sv
// transfer_sequencer
//   Moves one byte between register-file slots, or writes an immediate into a
//   slot, using a five-state sequence: IDLE -> READ -> CAPTURE -> WRITE -> DONE.
//   An immediate transfer skips READ and CAPTURE.
//
// Ports
//   clock          : clock; every transition happens on its rising edge
//   reset          : synchronous, active-high; aborts any transfer in flight
//   start          : one-cycle request, accepted only in IDLE
//   src_sel        : source register index (0-3)
//   dst_sel        : destination register index (0-3)
//   imm_en         : use imm_value as the source instead of a register
//   imm_value      : immediate operand
//   reg_values     : current contents of registers 0-3, register n on [8n+7:8n]
//   read_en        : one-hot read strobe, asserted in READ
//   write_en       : one-hot write strobe, asserted in WRITE
//   data_bus       : holding-latch value, valid when qualified by write_en
//   busy           : high whenever the sequencer is not in IDLE
//   done           : one-cycle completion pulse in DONE
//   transfer_count : (TRANSFER_COUNT_EN only) 16-bit wrapping count of
//                    completed transfers
//
// Configuration
//   `define TRANSFER_COUNT_EN to add the transfer_count output and counter.

module transfer_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  src_sel,
  input  logic [1:0]  dst_sel,
  input  logic        imm_en,
  input  logic [7:0]  imm_value,
  input  logic [31:0] reg_values,
  output logic [3:0]  read_en,
  output logic [3:0]  write_en,
  output logic [7:0]  data_bus,
  output logic        busy,
  output logic        done
`ifdef TRANSFER_COUNT_EN
  ,
  output logic [15:0] transfer_count
`endif
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          src_q;
  logic [1:0]          dst_q;
  logic                imm_q;
  logic [DATA_W-1:0]   hold_q;
  logic [DATA_W-1:0]   cap_value;

  // Register slot addressed by the latched source index.
  always_comb begin
    cap_value = reg_values[7:0];
    case (src_q)
      2'd0: cap_value = reg_values[7:0];
      2'd1: cap_value = reg_values[15:8];
      2'd2: cap_value = reg_values[23:16];
      2'd3: cap_value = reg_values[31:24];
      default: cap_value = reg_values[7:0];
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start is only looked at in IDLE, so requests made
  // while busy are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = imm_en ? S_WRITE : S_READ;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_WRITE;
      S_WRITE:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Request fields and holding latch. An immediate is loaded at acceptance;
  // a register value is sampled at the edge that ends CAPTURE.
  always_ff @(posedge clock) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      imm_q  <= 1'b0;
      hold_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      src_q <= src_sel;
      dst_q <= dst_sel;
      imm_q <= imm_en;
      if (imm_en) begin
        hold_q <= imm_value;
      end
    end else if (state_q == S_CAPTURE && !imm_q) begin
      hold_q <= cap_value;
    end
  end

  // Outputs decode from the state alone; the one-hot strobes are therefore
  // mutually exclusive by construction.
  always_comb begin
    read_en  = 4'b0000;
    write_en = 4'b0000;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    data_bus = hold_q;
    case (state_q)
      S_READ:  read_en  = 4'b0001 << src_q;
      S_WRITE: write_en = 4'b0001 << dst_q;
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

`ifdef TRANSFER_COUNT_EN
  logic [15:0] count_q;

  // Counts each DONE cycle as it completes; wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (state_q == S_DONE) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign transfer_count = count_q;
`endif

endmodule

// File: doc/transfer_sequencer.md
TRANSFER_SEQUENCER -- requirements
Module: transfer_sequencer

Interface
REQ-001 SHALL have ports: clock input 1 clock; reset input 1 synchronous, active-high reset.
REQ-002 SHALL have: start input 1, one-cycle transfer request.
REQ-003 SHALL have: src_sel input 2, source register index 0-3.
REQ-004 SHALL have: dst_sel input 2, destination register index 0-3.
REQ-005 SHALL have: imm_en input 1, source is imm_value instead of a register.
REQ-006 SHALL have: imm_value input 8, immediate operand.
REQ-007 SHALL have: reg_values input 32, valueOut of registers 0-3, register n on bits [8n+7:8n].
REQ-008 SHALL have: read_en output 4, per-register read_data strobes.
REQ-009 SHALL have: write_en output 4, per-register write_data strobes.
REQ-010 SHALL have: data_bus output 8, value driven to the registers' data_bus.
REQ-011 SHALL have: busy output 1, high whenever state is not IDLE.
REQ-012 SHALL have: done output 1, one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, READ, CAPTURE, WRITE, DONE. All transitions occur on posedge clock.
REQ-014 In IDLE with start=1, SHALL latch src_sel, dst_sel, imm_en and imm_value.
REQ-015 After a register-source start, SHALL go to READ; after an imm_en start, SHALL go directly to WRITE with the holding latch set to imm_value.
REQ-016 In READ (1 cycle), SHALL drive read_en one-hot at the latched src; all other strobes 0; next state is CAPTURE.
REQ-017 In CAPTURE (1 cycle), SHALL load the holding latch from reg_values[src] at the clock edge, with no strobes asserted; next state is WRITE.
REQ-018 In WRITE (1 cycle), SHALL drive data_bus from the holding latch and write_en one-hot at the latched dst; next state is DONE.
REQ-019 In DONE (1 cycle), SHALL pulse done=1 with no strobes; next state is IDLE.
REQ-020 Register-source latency SHALL be: start at cycle T, READ at T+1, CAPTURE at T+2, WRITE at T+3, done at T+4; next start accepted at T+5.
REQ-021 Immediate-source latency SHALL be: start at T, WRITE at T+1, done at T+2.
REQ-022 start outside IDLE SHALL be ignored, with no queuing and no effect on latched fields.
REQ-023 src_sel==dst_sel SHALL perform the normal full sequence.
REQ-024 At most one bit of read_en or write_en SHALL be high in any cycle; read_en and write_en SHALL never be high together.
REQ-025 data_bus SHALL hold the holding-latch value in all states; it is qualified only by write_en.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE and clear to 0: read_en, write_en, data_bus, busy, done, the holding latch and the latched fields.
REQ-027 reset during any state, including WRITE, SHALL abort the transfer: no write_en in the following cycle and no done pulse.
REQ-028 start asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-029 Macro TRANSFER_COUNT_EN: when defined, SHALL add output transfer_count, 16 bits.
REQ-030 With TRANSFER_COUNT_EN defined, transfer_count SHALL increment by 1 on each DONE cycle, wrap from 0xFFFF to 0x0000, and clear to 0 on reset.
REQ-031 Without TRANSFER_COUNT_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Register move: reg_values reg2=0x5A, start with src=2, dst=1 at T. Required: read_en=0100 at T+1; write_en=0010 with data_bus=0x5A at T+3; done at T+4.
REQ-033 Immediate: start with imm_en=1, imm_value=0xC3, dst=3 at T. Required: write_en=1000 with data_bus=0xC3 at T+1; done at T+2; read_en stays 0 throughout.
REQ-034 Busy reject: a second start at T+2 during a transfer is ignored. Required: only one write_en pulse, with the original dst and data.
REQ-035 Reset mid-op: reset asserted in the CAPTURE cycle. Required: next cycle is IDLE with all outputs 0, no write_en and no done.
REQ-036 Self-move: src=dst=0, reg0=0x11. Required: full 5-cycle sequence with data_bus=0x11 and write_en=0001.
REQ-037 Counter (TRANSFER_COUNT_EN defined): preload near-wrap by running 0xFFFF transfers, or force in simulation. Required: count 0xFFFF goes to 0x0000 on the next DONE; reset clears it to 0.
